// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-address width and the pipeline-register control bundle.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_MDU = 1'b1;

  typedef struct packed {
    logic stall_fetch;
    logic stall_decode;
    logic flush_decode;
    logic stall_execute;
    logic flush_execute;
    logic stall_memory;
    logic flush_memory;
    logic flush_writeback;
  } ctrl_t;

  // The first EX cycle of an MDU op is spent in RUN and the last one
  // reports completion, so the timer covers only the cycles in between.
  function automatic int mdu_load_cycles(input logic div, input int mul_lat, input int div_lat);
    return (div ? div_lat : mul_lat) - 2;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush controls out.
interface hazard_ctrl_if #(parameter int PERF_W = 32);
  import hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] rs_decode;
  logic [REG_ADDR_W-1:0] rt_decode;
  logic [REG_ADDR_W-1:0] rt_execute;
  logic                  memread_execute;
  logic                  branch_taken_decode;
  logic                  mdu_start_execute;
  logic                  mdu_div_execute;
  logic                  imem_ready;
  logic                  dmem_req_memory;
  logic                  dmem_ready;
  logic                  stall_fetch;
  logic                  stall_decode;
  logic                  flush_decode;
  logic                  stall_execute;
  logic                  flush_execute;
  logic                  stall_memory;
  logic                  flush_memory;
  logic                  flush_writeback;
  logic                  mdu_busy;
  logic                  mdu_done;
  logic [PERF_W-1:0]     stall_count;

  modport master (
    output rs_decode, rt_decode, rt_execute, memread_execute, branch_taken_decode,
           mdu_start_execute, mdu_div_execute, imem_ready, dmem_req_memory, dmem_ready,
    input  stall_fetch, stall_decode, flush_decode, stall_execute, flush_execute,
           stall_memory, flush_memory, flush_writeback, mdu_busy, mdu_done, stall_count
  );

  modport slave (
    input  rs_decode, rt_decode, rt_execute, memread_execute, branch_taken_decode,
           mdu_start_execute, mdu_div_execute, imem_ready, dmem_req_memory, dmem_ready,
    output stall_fetch, stall_decode, flush_decode, stall_execute, flush_execute,
           stall_memory, flush_memory, flush_writeback, mdu_busy, mdu_done, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Loadable down-counter timing MUL/DIV occupancy of EX; flags zero.
module hazard_ctrl_mdu_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: prioritised
// hazard resolution, MUL/DIV occupancy FSM and saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  logic [0:0]        r_state;
  logic [0:0]        w_next;
  logic              w_dw;
  logic              w_lu;
  logic              w_mb;
  logic              w_done;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic [CNT_W-1:0]  w_load_val;
  logic [PERF_W-1:0] r_stall_count;
  ctrl_t             w_ctrl;

  assign w_dw = bus.dmem_req_memory & ~bus.dmem_ready;
  assign w_lu = bus.memread_execute
              & (bus.rt_execute != {REG_ADDR_W{1'b0}})
              & ((bus.rt_execute == bus.rs_decode) | (bus.rt_execute == bus.rt_decode));
  assign w_load_val = CNT_W'(mdu_load_cycles(bus.mdu_div_execute, MUL_LAT, DIV_LAT));

  hazard_ctrl_mdu_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // MDU sequencing: entry is retried while data memory is waiting, and
  // completion is deferred until the data-memory wait clears.
  always_comb begin
    w_next = r_state;
    w_mb   = 1'b0;
    w_done = 1'b0;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.mdu_start_execute) begin
          w_mb = 1'b1;
          if (!w_dw) begin
            w_next = ST_MDU;
            w_load = 1'b1;
          end else begin
            w_next = ST_RUN;
          end
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_MDU: begin
        if (!w_zero) begin
          w_mb  = 1'b1;
          w_dec = 1'b1;
        end else if (!w_dw) begin
          w_done = 1'b1;
          w_next = ST_RUN;
        end else begin
          w_next = ST_MDU;
        end
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Priority resolution; flush and stall of one register never coincide.
  always_comb begin
    w_ctrl = ctrl_t'(8'h00);
    if (!rst) begin
      w_ctrl = ctrl_t'(8'h00);
    end else if (w_dw) begin
      w_ctrl.stall_fetch     = 1'b1;
      w_ctrl.stall_decode    = 1'b1;
      w_ctrl.stall_execute   = 1'b1;
      w_ctrl.stall_memory    = 1'b1;
      w_ctrl.flush_writeback = 1'b1;
    end else if (w_mb) begin
      w_ctrl.stall_fetch   = 1'b1;
      w_ctrl.stall_decode  = 1'b1;
      w_ctrl.stall_execute = 1'b1;
      w_ctrl.flush_memory  = 1'b1;
    end else if (w_lu) begin
      w_ctrl.stall_fetch   = 1'b1;
      w_ctrl.stall_decode  = 1'b1;
      w_ctrl.flush_execute = 1'b1;
    end else if (bus.branch_taken_decode) begin
      w_ctrl.flush_decode = 1'b1;
    end else if (!bus.imem_ready) begin
      w_ctrl.stall_fetch  = 1'b1;
      w_ctrl.flush_decode = 1'b1;
    end else begin
      w_ctrl = ctrl_t'(8'h00);
    end
  end

  // Saturating count of PC-hold cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= {PERF_W{1'b0}};
    end else if (w_ctrl.stall_fetch && (r_stall_count != {PERF_W{1'b1}})) begin
      r_stall_count <= r_stall_count + PERF_W'(1);
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign bus.stall_fetch     = w_ctrl.stall_fetch;
  assign bus.stall_decode    = w_ctrl.stall_decode;
  assign bus.flush_decode    = w_ctrl.flush_decode;
  assign bus.stall_execute   = w_ctrl.stall_execute;
  assign bus.flush_execute   = w_ctrl.flush_execute;
  assign bus.stall_memory    = w_ctrl.stall_memory;
  assign bus.flush_memory    = w_ctrl.flush_memory;
  assign bus.flush_writeback = w_ctrl.flush_writeback;
  assign bus.mdu_busy        = (r_state == ST_MDU);
  assign bus.mdu_done        = w_done & rst;
  assign bus.stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int PERF_W  = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rte;
    logic       memrd;
    logic       br;
    logic       start;
    logic       div;
    logic       imem;
    logic       dreq;
    logic       dready;
  } stim_t;

  typedef struct packed {
    logic [9:0]        f;
    logic [PERF_W-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc_n  = 0;

  // Model state: whether an MDU op owns EX and how many cycles it still needs.
  bit m_in   = 1'b0;
  int m_left = 0;
  int m_cnt  = 0;
  bit last_done = 1'b0;
  bit pending = 1'b0;
  bit pend_div = 1'b0;

  function automatic void model(input stim_t s, output logic [9:0] ef, output logic [PERF_W-1:0] ec);
    bit dw, lu, mb, done, busy;
    bit sf, sd, fd, se, fe, sm, fm, fw;
    last_done = 1'b0;
    if (!s.rst) begin
      ef = 10'd0; ec = '0;
      m_in = 1'b0; m_left = 0; m_cnt = 0;
      return;
    end
    ec   = PERF_W'(m_cnt);
    dw   = s.dreq && !s.dready;
    lu   = s.memrd && (s.rte != 5'd0) && ((s.rte == s.rs) || (s.rte == s.rt));
    busy = m_in;
    mb = 1'b0; done = 1'b0;
    if (!m_in) begin
      if (s.start) begin
        mb = 1'b1;
        if (!dw) begin m_in = 1'b1; m_left = (s.div ? DIV_LAT : MUL_LAT) - 1; end
      end
    end else if (m_left > 1) begin
      mb = 1'b1; m_left--;
    end else if (!dw) begin
      done = 1'b1; m_in = 1'b0;
    end
    {sf, sd, fd, se, fe, sm, fm, fw} = 8'd0;
    if (dw)              begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
    else if (mb)         begin sf = 1; sd = 1; se = 1; fm = 1; end
    else if (lu)         begin sf = 1; sd = 1; fe = 1; end
    else if (s.br)       begin fd = 1; end
    else if (!s.imem)    begin sf = 1; fd = 1; end
    ef = {sf, sd, fd, se, fe, sm, fm, fw, busy, done};
    if (sf && m_cnt < (2 ** PERF_W) - 1) m_cnt++;
    last_done = done;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.rte = 5'd3;
    s.memrd = 1'b0; s.br = 1'b0; s.start = 1'b0; s.div = 1'b0;
    s.imem = 1'b1; s.dreq = 1'b0; s.dready = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst                     = s.rst;
    bus.rs_decode           = s.rs;
    bus.rt_decode           = s.rt;
    bus.rt_execute          = s.rte;
    bus.memread_execute     = s.memrd;
    bus.branch_taken_decode = s.br;
    bus.mdu_start_execute   = s.start;
    bus.mdu_div_execute     = s.div;
    bus.imem_ready          = s.imem;
    bus.dmem_req_memory     = s.dreq;
    bus.dmem_ready          = s.dready;
    model(s, e.f, e.c);
    exp_q.push_back(e);
  endtask

  // Drives an MDU op held in EX until the model reports completion.
  task automatic run_mdu(input bit div, input int limit);
    stim_t s;
    s = idle(); s.start = 1'b1; s.div = div;
    for (int i = 0; i < limit; i++) begin
      cyc(s);
      if (last_done) break;
    end
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = exp_q.pop_front();
      cyc_n++;
      act = {bus.stall_fetch, bus.stall_decode, bus.flush_decode, bus.stall_execute,
             bus.flush_execute, bus.stall_memory, bus.flush_memory, bus.flush_writeback,
             bus.mdu_busy, bus.mdu_done};
      checks++;
      if (act !== e.f) $display("FAIL ctrl cyc=%0d got=%b exp=%b", cyc_n, act, e.f);
      else passed++;
      checks++;
      if (bus.stall_count !== e.c) $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc_n, bus.stall_count, e.c);
      else passed++;
    end
  end

  initial begin
    stim_t s;
    bus.rs_decode = 5'd0; bus.rt_decode = 5'd0; bus.rt_execute = 5'd0;
    bus.memread_execute = 1'b0; bus.branch_taken_decode = 1'b0;
    bus.mdu_start_execute = 1'b0; bus.mdu_div_execute = 1'b0;
    bus.imem_ready = 1'b1; bus.dmem_req_memory = 1'b0; bus.dmem_ready = 1'b1;

    s = idle(); s.rst = 1'b0;
    repeat (3) cyc(s);
    cyc(idle());

    // Load-use hit, then the same with $zero as destination.
    s = idle(); s.memrd = 1'b1; s.rte = 5'd5; s.rs = 5'd5;
    cyc(s); cyc(idle());
    s.rte = 5'd0; s.rs = 5'd0;
    cyc(s); cyc(idle());

    // Taken branch alone, then masked by a load-use.
    s = idle(); s.br = 1'b1;
    cyc(s);
    s.memrd = 1'b1; s.rte = 5'd7; s.rt = 5'd7;
    cyc(s); cyc(idle());

    run_mdu(1'b0, 20);
    cyc(idle());

    // Divide with a data-memory wait over its final cycles.
    s = idle(); s.start = 1'b1; s.div = 1'b1;
    for (int i = 0; i < 27; i++) cyc(s);
    s.dreq = 1'b1; s.dready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(s);
    s.dreq = 1'b0; s.dready = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(s); if (last_done) break; end
    cyc(idle());

    // Reset in the middle of a divide, then a fresh multiply.
    s = idle(); s.start = 1'b1; s.div = 1'b1;
    for (int i = 0; i < 10; i++) cyc(s);
    s = idle(); s.rst = 1'b0;
    cyc(s); cyc(s);
    run_mdu(1'b0, 20);
    cyc(idle());

    // Instruction-memory wait long enough to saturate the counter.
    s = idle(); s.imem = 1'b0;
    for (int i = 0; i < 20; i++) cyc(s);
    s = idle(); s.rst = 1'b0;
    cyc(s);

    // Random traffic with MDU ops held in EX until completion.
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.rte   = 5'($urandom_range(0, 3));
      s.memrd = ($urandom_range(0, 3) == 0);
      s.br    = ($urandom_range(0, 7) == 0);
      s.imem  = ($urandom_range(0, 7) != 0);
      s.dreq  = ($urandom_range(0, 2) == 0);
      s.dready = ($urandom_range(0, 1) == 0);
      s.rst   = ($urandom_range(0, 149) != 0);
      if (!pending && $urandom_range(0, 9) == 0) begin
        pending = 1'b1; pend_div = ($urandom_range(0, 3) == 0);
      end
      s.start = pending; s.div = pend_div;
      cyc(s);
      if (last_done || !s.rst) pending = 1'b0;
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
